// File: rtl/fpmul_arbiter_if.sv
// Bundle between the requester units, the shared-multiplier arbiter and the
// fpmul instance. "slave" is the arbiter's view, "master" the environment's.
interface fpmul_arbiter_if #(
    parameter int N = 4
);
    // Requester side
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [16*N-1:0] req_x1;
    logic [16*N-1:0] req_x2;
    logic            hold;
    // Multiplier side
    logic [15:0]     mul_x1;
    logic [15:0]     mul_x2;
    logic            mul_en;
    logic [15:0]     mul_y;
    logic            mul_ready;
    // Results and status
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_y;
    logic            busy;
    logic            err;

    modport slave (
        input  req_valid, req_x1, req_x2, hold, mul_y, mul_ready,
        output req_ready, mul_x1, mul_x2, mul_en, rsp_valid, rsp_y, busy, err
    );

    modport master (
        output req_valid, req_x1, req_x2, hold, mul_y, mul_ready,
        input  req_ready, mul_x1, mul_x2, mul_en, rsp_valid, rsp_y, busy, err
    );
endinterface

// File: rtl/fpmul_arbiter.sv
// Shares one pipelined bfloat16 multiplier between N requesters. Grants at most
// one issue per cycle round-robin, tags each issue with its requester index in
// a LAT-deep pipeline aligned to mul_ready, and returns each result to its
// owner one cycle after the multiplier raises ready.
// Optional feature macro: FPMUL_ARB_PRIO_EN gives requester 0 absolute
// priority; the remaining requesters share round-robin among themselves.
module fpmul_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    fpmul_arbiter_if.slave bus
);
    localparam int CW = $clog2(LAT + 2);

    logic [IDW-1:0] rr_ptr;
    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    int             idx;
    logic [IDW+3:0] grant_lsb;
    logic [LAT-1:0] tag_vld;
    logic [IDW-1:0] tag_id [LAT];
    logic [CW-1:0]  inflight;
    logic [N-1:0]   rsp_valid;
    logic [15:0]    rsp_y;
    logic           err;

    // Pick the first valid requester searching cyclically from rr_ptr+1.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        idx       = 0;
        if (!rst && !bus.hold) begin
`ifdef FPMUL_ARB_PRIO_EN
            if (bus.req_valid[0]) begin
                grant_vld = 1'b1;
            end
`endif
            for (int k = 1; k <= N; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N) idx = idx - N;
                cand = IDW'(idx);
`ifdef FPMUL_ARB_PRIO_EN
                if (!grant_vld && cand != '0 && bus.req_valid[cand]) begin
`else
                if (!grant_vld && bus.req_valid[cand]) begin
`endif
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign grant_lsb  = {grant_idx, 4'b0000};
    assign bus.mul_en = grant_vld;

    // Present the granted requester's operands to the multiplier; zero when idle.
    always_comb begin
        bus.req_ready = '0;
        bus.mul_x1    = '0;
        bus.mul_x2    = '0;
        if (grant_vld) begin
            bus.req_ready[grant_idx] = 1'b1;
            bus.mul_x1 = bus.req_x1[grant_lsb +: 16];
            bus.mul_x2 = bus.req_x2[grant_lsb +: 16];
        end
    end

    // Remember the last round-robin winner so the search starts just past it.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rr_ptr <= IDW'(N - 1);
        end else if (grant_vld) begin
`ifdef FPMUL_ARB_PRIO_EN
            if (grant_idx != '0) rr_ptr <= grant_idx;
`else
            rr_ptr <= grant_idx;
`endif
        end
    end

    // Valid bits of the tag pipeline; the last stage lines up with mul_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tag_vld <= '0;
        else     tag_vld <= (tag_vld << 1) | LAT'(grant_vld);
    end

    // Requester ids travelling alongside the valid bits.
    // NOTE: ids mean nothing without their valid bit, so this storage is not reset.
    always_ff @(posedge clk) begin
        tag_id[0] <= grant_idx;
        for (int s = 1; s < LAT; s++) tag_id[s] <= tag_id[s-1];
    end

    // Register the result toward its owner and flag any tag/ready disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_y     <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (bus.mul_ready && tag_vld[LAT-1]) begin
                rsp_valid[tag_id[LAT-1]] <= 1'b1;
                rsp_y                    <= bus.mul_y;
            end
            if (bus.mul_ready != tag_vld[LAT-1]) err <= 1'b1;
        end
    end

    // Count operations from issue until their response pulse has been delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({grant_vld, |rsp_valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_y     = rsp_y;
    assign bus.err       = err;
    assign bus.busy      = (inflight != '0);
endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter. A behavioural bfloat16 multiplier
// stands in for fpmul; a queue-based reference model predicts grants,
// responses, busy and err every cycle from the arbitration rules.
module tb_fpmul_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 3;
    localparam int OW  = 2 * N + 51;

    typedef struct packed {
        int          due;
        int          id;
        logic [15:0] y;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic inject;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;

    fpmul_arbiter_if #(.N(N)) bus ();

    fpmul_arbiter #(.N(N), .IDW(IDW), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Truncating bfloat16 multiply for normal operands.
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        logic [6:0]  m;
        int          e;
        p = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            m = p[14:8];
            e = e + 1;
        end else begin
            m = p[13:7];
        end
        return {a[15] ^ b[15], e[7:0], m};
    endfunction

    // fpmul stand-in: LAT-cycle pipeline, reset by the same rst.
    logic [LAT-1:0] pv;
    logic [15:0]    py [LAT];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int s = 0; s < LAT; s++) py[s] <= '0;
        end else begin
            pv    <= (pv << 1) | LAT'(bus.mul_en);
            py[0] <= bf16_mul(bus.mul_x1, bus.mul_x2);
            for (int s = 1; s < LAT; s++) py[s] <= py[s-1];
        end
    end
    assign bus.mul_ready = pv[LAT-1] | inject;
    assign bus.mul_y     = py[LAT-1];

    logic [OW-1:0] obs;
    assign obs = {bus.req_ready, bus.mul_en, bus.mul_x1, bus.mul_x2,
                  bus.rsp_valid, bus.rsp_y, bus.busy, bus.err};

    // Reference model state
    rsp_t          m_q[$];
    int            m_ptr;
    int            m_count;
    logic [15:0]   m_y;
    logic          m_err;
    int            e_grant;
    logic          e_hit;
    rsp_t          e_rsp;
    logic [OW-1:0] exp_vec;

    task automatic model_clear();
        m_q.delete();
        m_ptr   = N - 1;
        m_count = 0;
        m_y     = '0;
        m_err   = 1'b0;
    endtask

    function automatic int model_grant();
        int i;
        if (rst || bus.hold) return -1;
`ifdef FPMUL_ARB_PRIO_EN
        if (bus.req_valid[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            i = (m_ptr + k) % N;
`ifdef FPMUL_ARB_PRIO_EN
            if (i != 0 && bus.req_valid[i]) return i;
`else
            if (bus.req_valid[i]) return i;
`endif
        end
        return -1;
    endfunction

    // Wait to mid-cycle and build the expected output vector for this cycle.
    task automatic sample();
        logic [N-1:0] ex_ready, ex_rv;
        logic [15:0]  ex_x1, ex_x2, ex_y;
        @(negedge clk);
        if (rst) model_clear();
        e_grant  = model_grant();
        e_hit    = (m_q.size() > 0) && (m_q[0].due == cyc);
        ex_ready = '0;
        ex_x1    = '0;
        ex_x2    = '0;
        ex_rv    = '0;
        ex_y     = m_y;
        if (e_grant >= 0) begin
            ex_ready = N'(1) << e_grant;
            ex_x1    = bus.req_x1[16*e_grant +: 16];
            ex_x2    = bus.req_x2[16*e_grant +: 16];
        end
        if (e_hit) begin
            e_rsp = m_q[0];
            ex_rv = N'(1) << e_rsp.id;
            ex_y  = e_rsp.y;
        end
        exp_vec = {ex_ready, e_grant >= 0, ex_x1, ex_x2, ex_rv, ex_y, m_count != 0, m_err};
    endtask

    // Commit this cycle's events to the model, then move to just after the next edge.
    task automatic advance();
        rsp_t r;
        if (!rst) begin
            if (e_hit) begin
                void'(m_q.pop_front());
                m_y     = e_rsp.y;
                m_count = m_count - 1;
            end
            if (inject && !(m_q.size() > 0 && m_q[0].due == cyc + 1)) m_err = 1'b1;
            if (e_grant >= 0) begin
                r.due = cyc + LAT + 1;
                r.id  = e_grant;
                r.y   = bf16_mul(bus.req_x1[16*e_grant +: 16], bus.req_x2[16*e_grant +: 16]);
                m_q.push_back(r);
                m_count = m_count + 1;
`ifdef FPMUL_ARB_PRIO_EN
                if (e_grant != 0) m_ptr = e_grant;
`else
                m_ptr = e_grant;
`endif
            end
        end
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            sample();
            advance();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_x1[16*i +: 16] = a;
        bus.req_x2[16*i +: 16] = b;
    endtask

    function automatic logic [15:0] rand_bf16();
        return {1'($urandom_range(1)), 8'($urandom_range(134, 120)), 7'($urandom)};
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            sample();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fails++;
                $display("FAIL reset_outputs cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
            end
            n_checks++;
            if ({bus.req_ready, bus.mul_en, bus.busy, bus.err, bus.rsp_y} !== '0) begin
                n_fails++;
                $display("FAIL reset_zero cyc=%0d got=%h want=0", cyc,
                         {bus.req_ready, bus.mul_en, bus.busy, bus.err, bus.rsp_y});
            end
            advance();
            rst = 1'b0;
        end
    endtask

    task automatic test_single_issue();
        set_op(0, 16'h3FC0, 16'h4000);
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            sample();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fails++;
                $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
            end
            n_checks++;
            if (bus.busy !== (k >= 1 && k <= 4)) begin
                n_fails++;
                $display("FAIL single_busy k=%0d got=%b want=%b", k, bus.busy, (k >= 1 && k <= 4));
            end
            if (k == 0) begin
                n_checks++;
                if (bus.req_ready !== 4'b0001) begin
                    n_fails++;
                    $display("FAIL single_grant got=%b want=0001", bus.req_ready);
                end
            end
            if (k == 4) begin
                n_checks++;
                if (bus.rsp_valid !== 4'b0001 || bus.rsp_y !== 16'h4040) begin
                    n_fails++;
                    $display("FAIL single_rsp got=%b/%h want=0001/4040", bus.rsp_valid, bus.rsp_y);
                end
            end
            advance();
            bus.req_valid = '0;
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, rand_bf16(), rand_bf16());
        set_op(2, 16'h4040, 16'h4000);
        bus.req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            if (k == 6) bus.req_valid = '0;
            sample();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fails++;
                $display("FAIL fair cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
            end
            if (k < 6) begin
                n_checks++;
                if (bus.req_ready !== N'(1) << (k % N)) begin
                    n_fails++;
                    $display("FAIL fair_grant k=%0d got=%b want=%b", k, bus.req_ready, N'(1) << (k % N));
                end
            end
            if (k >= 4 && k < 10) begin
                n_checks++;
                if (bus.rsp_valid !== N'(1) << ((k - 4) % N)) begin
                    n_fails++;
                    $display("FAIL fair_rsp k=%0d got=%b want=%b", k, bus.rsp_valid, N'(1) << ((k - 4) % N));
                end
            end
            if (k == 6) begin
                n_checks++;
                if (bus.rsp_y !== 16'h40C0) begin
                    n_fails++;
                    $display("FAIL fair_req2_y got=%h want=40c0", bus.rsp_y);
                end
            end
            advance();
        end
    endtask

    task automatic test_prio();
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, rand_bf16(), rand_bf16());
        bus.req_valid = 4'b0011;
        for (int k = 0; k < 13; k++) begin
            if (k == 6) bus.req_valid = 4'b0010;
            if (k == 7) bus.req_valid = '0;
            sample();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fails++;
                $display("FAIL prio cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
            end
            if (k <= 6) begin
                n_checks++;
                if (bus.req_ready !== ((k < 6) ? 4'b0001 : 4'b0010)) begin
                    n_fails++;
                    $display("FAIL prio_grant k=%0d got=%b want=%b", k, bus.req_ready,
                             (k < 6) ? 4'b0001 : 4'b0010);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        set_op(3, rand_bf16(), rand_bf16());
        bus.req_valid = 4'b1000;
        for (int k = 0; k < 11; k++) begin
            if (k == 6) bus.req_valid = '0;
            if (k > 0 && k < 6) set_op(3, rand_bf16(), rand_bf16());
            sample();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fails++;
                $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
            end
            if (k < 6) begin
                n_checks++;
                if (bus.req_ready !== 4'b1000) begin
                    n_fails++;
                    $display("FAIL b2b_grant k=%0d got=%b want=1000", k, bus.req_ready);
                end
            end
            advance();
        end
    endtask

    task automatic test_hold_drain();
        int rsp_seen;
        rsp_seen = 0;
        for (int i = 0; i < N; i++) set_op(i, rand_bf16(), rand_bf16());
        bus.req_valid = '1;
        bus.hold      = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) bus.hold = 1'b1;
            sample();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fails++;
                $display("FAIL hold cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
            end
            if (k >= 3) begin
                n_checks++;
                if (bus.req_ready !== '0) begin
                    n_fails++;
                    $display("FAIL hold_grant k=%0d got=%b want=0000", k, bus.req_ready);
                end
            end
            if (k == 6 || k == 7) begin
                n_checks++;
                if (bus.busy !== (k == 6)) begin
                    n_fails++;
                    $display("FAIL hold_busy k=%0d got=%b want=%b", k, bus.busy, (k == 6));
                end
            end
            if (bus.rsp_valid != '0) rsp_seen++;
            advance();
        end
        n_checks++;
        if (rsp_seen != 3) begin
            n_fails++;
            $display("FAIL hold_rsp_count got=%0d want=3", rsp_seen);
        end
        bus.req_valid = '0;
        bus.hold      = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            if (k < 292) begin
                bus.req_valid = N'($urandom);
                bus.hold      = ($urandom_range(7) == 0);
                for (int i = 0; i < N; i++) set_op(i, rand_bf16(), rand_bf16());
            end else begin
                bus.req_valid = '0;
                bus.hold      = 1'b0;
            end
            sample();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fails++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        set_op(1, rand_bf16(), rand_bf16());
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            if (k == 1) bus.req_valid = '0;
            if (k == 2) rst = 1'b1;
            if (k == 3) rst = 1'b0;
            if (k == 9) bus.req_valid = '1;
            sample();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fails++;
                $display("FAIL rst_mid cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
            end
            if (k >= 2) begin
                n_checks++;
                if (bus.rsp_valid !== '0 || bus.err !== 1'b0 || (k < 9 && bus.busy !== 1'b0)) begin
                    n_fails++;
                    $display("FAIL rst_mid_quiet k=%0d got rsp=%b err=%b busy=%b want 0", k,
                             bus.rsp_valid, bus.err, bus.busy);
                end
            end
            if (k == 9) begin
                n_checks++;
                if (bus.req_ready !== 4'b0001) begin
                    n_fails++;
                    $display("FAIL rst_mid_grant got=%b want=0001", bus.req_ready);
                end
            end
            advance();
        end
        bus.req_valid = '0;
        idle(6);
    endtask

    task automatic test_error_injection();
        inject = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fails++;
                $display("FAIL err_inj cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
            end
            if (k > 0) begin
                n_checks++;
                if (bus.err !== 1'b1 || bus.rsp_valid !== '0) begin
                    n_fails++;
                    $display("FAIL err_sticky k=%0d got err=%b rsp=%b want 1/0000", k, bus.err, bus.rsp_valid);
                end
            end
            advance();
            inject = 1'b0;
        end
        do_reset();
        sample();
        n_checks++;
        if (bus.err !== 1'b0 || obs !== exp_vec) begin
            n_fails++;
            $display("FAIL err_clear got err=%b vec=%h want err=0 vec=%h", bus.err, obs, exp_vec);
        end
        advance();
    endtask

    initial begin
        rst           = 1'b1;
        inject        = 1'b0;
        bus.req_valid = '0;
        bus.req_x1    = '0;
        bus.req_x2    = '0;
        bus.hold      = 1'b0;
        model_clear();
        test_reset();
        test_single_issue();
`ifdef FPMUL_ARB_PRIO_EN
        test_prio();
`else
        test_fairness();
`endif
        test_back_to_back();
        test_hold_drain();
        idle(4);
        test_random();
        test_reset_midflight();
        test_error_injection();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fpmul_arbiter.md
Name: fpmul_arbiter

Overview:
- Shares one pipelined bfloat16 multiplier (`fpmul`) between N requesters.
- Accepts operand pairs through per-requester valid/ready handshakes and grants at most one issue per cycle, round-robin.
- Drives the multiplier's x1/x2/en inputs and tags every issue with its requester index.
- Steers each result back to the right requester when the multiplier raises ready.
- Sits between the requester units and the `fpmul` instance.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester index width; must satisfy 2^IDW >= N.
- LAT, 3, multiplier latency in cycles from en sampled high to ready high.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N  per-requester operand-pair valid.
- req_ready  out  N  per-requester grant; a transfer occurs when valid&ready.
- req_x1  in  16*N  operand A, requester i at bits [16i+15:16i].
- req_x2  in  16*N  operand B, same packing as req_x1.
- hold  in  1  when high, no new grants; in-flight operations drain.
- mul_x1  out  16  to fpmul x1.
- mul_x2  out  16  to fpmul x2.
- mul_en  out  1  to fpmul en.
- mul_y  in  16  from fpmul y.
- mul_ready  in  1  from fpmul ready.
- rsp_valid  out  N  one-hot, one-cycle pulse marking the result owner.
- rsp_y  out  16  result, broadcast to all requesters.
- busy  out  1  high while any operation is in flight.
- err  out  1  sticky; set on tag/ready mismatch.

Behaviour:
- Reset (async, rst=1):
  - rr_ptr=N-1; tag pipeline valid bits=0; inflight=0; err=0.
  - Outputs: req_ready=0, mul_en=0, rsp_valid=0, rsp_y=0, busy=0, mul_x1/mul_x2=0.
- Arbitration (combinational from registered state):
  - When hold=0, grant the lowest index i with req_valid[i]=1, searching cyclically from rr_ptr+1 (mod N).
  - req_ready is one-hot or zero. req_ready[i] never asserts without req_valid[i].
- Issue:
  - mul_en = |req_ready. mul_x1/mul_x2 are a mux of the granted requester's operands; 0 when there is no grant.
  - On issue, at the clock edge: rr_ptr <= granted index, and the tag pipeline stage 0 loads {1, index}.
- Tag pipeline:
  - LAT stages of {valid, IDW-bit id}, shifting every cycle with no stall. One issue per cycle is sustainable.
  - The last stage aligns with mul_ready: issue in cycle t produces mul_ready in cycle t+LAT.
- Response (registered, one cycle after mul_ready):
  - If mul_ready=1 and the last stage is valid: rsp_valid[id] <= 1 and rsp_y <= mul_y.
  - rsp_y holds its value when no response is issued.
  - Requesters cannot backpressure and must accept rsp_valid in the cycle it is high.
  - Total issue-to-rsp_valid latency is LAT+1 cycles.
- Error check:
  - mul_ready=1 with last stage invalid, or last stage valid with mul_ready=0, sets err=1.
  - On mul_ready with the last stage invalid, rsp_valid stays 0. err clears only on rst.
- inflight counter:
  - Width sized for 0..LAT+1; +1 on issue, −1 on response.
  - Simultaneous issue and response leaves it unchanged.
  - busy = (inflight != 0).
- Boundary conditions:
  - Single active requester: granted every cycle, back-to-back.
  - rr_ptr wraps from N-1 to 0.
  - hold raised mid-stream: already-issued operations still complete.
  - rst mid-operation: all tags dropped, and any later stray mul_ready is ignored, provided fpmul is reset by the same rst.

Optional Feature:
- Macro: FPMUL_ARB_PRIO_EN.
- Defined: requester 0 has fixed absolute priority. If req_valid[0]=1 and hold=0, it is granted regardless of rr_ptr, and rr_ptr is not updated by a requester-0 grant. All other requesters arbitrate round-robin among themselves.
- Undefined: pure round-robin over all N requesters, as described above.

Test Plan:
- Single issue: req0 issues x1=0x3FC0 (1.5), x2=0x4000 (2.0) at cycle 0 → req_ready[0]=1 in cycle 0; mul_ready in cycle 3; rsp_valid=4'b0001 and rsp_y=0x4040 in cycle 4; busy high in cycles 1..4; err=0.
- Fairness: all four requesters valid continuously → grants 0,1,2,3,0,1 on consecutive cycles; responses appear in the same order, one per cycle, each rsp_y matching its own operands (e.g. req2: 0x4040×0x4000 → 0x40C0).
- Hold drain: three operations issued, then hold=1 → no further req_ready; all three responses still arrive; busy falls to 0 one cycle after the last rsp_valid.
- Reset mid-flight: rst pulsed two cycles after an issue → rsp_valid stays 0 thereafter; busy=0 immediately; err=0; rr_ptr restarts so the next grant goes to requester 0.
- Error injection: bench forces mul_ready=1 with no issue outstanding → err=1 latched and rsp_valid=0; err stays high until rst.
- With FPMUL_ARB_PRIO_EN: req0 and req1 valid continuously → req0 granted every cycle and req1 never granted; dropping req0 valid → req1 granted the next cycle.
